keypad_scanner: RTL and testbench

Matrix-keypad front end for the keypad/FND display path. Drives the 4 active-low column lines one at a time, samples the 5 active-low row lines, debounces, and emits a single-cycle key event with a 5-bit key code (0..19). That event feeds the downstream FND digit/display logic.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner_scan_strobe.sv | 27 ++
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan front end.
// Geometry of the 4x5 matrix, FSM states and code/column mapping.
package keypad_pkg;

    localparam int NUM_ROWS   = 5;
    localparam int NUM_COLS   = 4;
    localparam int KEY_CODE_W = 5;
    localparam int COL_W      = 2;
    localparam int ROW_W      = 3;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HELD
    } state_t;

    function automatic logic [NUM_COLS-1:0] col_onehot_n(
        input logic [COL_W-1:0] col
    );
        return ~(NUM_COLS'(1) << col);
    endfunction

    function automatic logic [KEY_CODE_W-1:0] key_code_of(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row
    );
        return KEY_CODE_W'(col) * KEY_CODE_W'(NUM_ROWS)
             + KEY_CODE_W'(row);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key event bundle handed to the display path.
// The scanner is the master; the matrix/consumer side is the slave.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0]   key_row;
    logic [NUM_COLS-1:0]   key_col;
    logic                  key_valid;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_pressed;

    modport master (
        input  key_row,
        output key_col,
        output key_valid,
        output key_code,
        output key_pressed
    );

    modport slave (
        output key_row,
        input  key_col,
        input  key_valid,
        input  key_code,
        input  key_pressed
    );

endinterface

// File: rtl/keypad_scanner_scan_strobe.sv
// Column-slot divider: one strobe per SCAN_DIV cycles,
// asserted on the last cycle of each slot.
module scan_strobe #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic strobe
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div;

    assign strobe = (div == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (strobe) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sync, debounce FSM
// and single-cycle key events with a col*5+row code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp
);

    localparam int CNT_W = $clog2(DEB_CNT + 1);

    logic [NUM_ROWS-1:0]   row_s1;
    logic [NUM_ROWS-1:0]   row_s2;
    logic                  strobe;
    logic                  row_hit;
    logic [ROW_W-1:0]      row_idx;

    state_t                state;
    state_t                state_nxt;
    logic [COL_W-1:0]      col;
    logic [COL_W-1:0]      col_nxt;
    logic [COL_W-1:0]      cand_col;
    logic [COL_W-1:0]      cand_col_nxt;
    logic [ROW_W-1:0]      cand_row;
    logic [ROW_W-1:0]      cand_row_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  deb_done;
    logic                  valid;
    logic                  valid_nxt;
    logic [KEY_CODE_W-1:0] code;
    logic [KEY_CODE_W-1:0] code_nxt;
    logic                  pressed;
    logic                  pressed_nxt;

    scan_strobe #(
        .SCAN_DIV (SCAN_DIV)
    ) u_strobe (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe)
    );

    // Rows are asynchronous to clk; two flops before any use.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= kp.key_row;
            row_s2 <= row_s1;
        end
    end

    // Lowest-numbered closed row wins on multi-key presses.
    always_comb begin
        row_hit = 1'b0;
        row_idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!row_s2[i]) begin
                row_hit = 1'b1;
                row_idx = ROW_W'(i);
            end
        end
    end

    assign cnt_inc  = cnt + CNT_W'(1);
    assign deb_done = (cnt_inc == CNT_W'(DEB_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            col      <= '0;
            cand_col <= '0;
            cand_row <= '0;
            cnt      <= '0;
            valid    <= 1'b0;
            code     <= '0;
            pressed  <= 1'b0;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            cand_col <= cand_col_nxt;
            cand_row <= cand_row_nxt;
            cnt      <= cnt_nxt;
            valid    <= valid_nxt;
            code     <= code_nxt;
            pressed  <= pressed_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        col_nxt      = col;
        cand_col_nxt = cand_col;
        cand_row_nxt = cand_row;
        cnt_nxt      = cnt;
        valid_nxt    = 1'b0;
        code_nxt     = code;
        pressed_nxt  = pressed;
        if (strobe) begin
            unique case (state)
                SCAN: begin
                    if (!row_hit) begin
                        col_nxt = col + COL_W'(1);
                    end else begin
                        cand_col_nxt = col;
                        cand_row_nxt = row_idx;
                        if (DEB_CNT == 1) begin
                            valid_nxt   = 1'b1;
                            code_nxt    = key_code_of(col, row_idx);
                            pressed_nxt = 1'b1;
                            cnt_nxt     = '0;
                            state_nxt   = HELD;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = PRESS_DEB;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (row_hit && row_idx == cand_row) begin
                        if (deb_done) begin
                            valid_nxt   = 1'b1;
                            code_nxt    = key_code_of(cand_col, cand_row);
                            pressed_nxt = 1'b1;
                            cnt_nxt     = '0;
                            state_nxt   = HELD;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        col_nxt   = col + COL_W'(1);
                        state_nxt = SCAN;
                    end
                end
                HELD: begin
                    // Only the held key's row matters; others are ignored.
                    if (row_s2[cand_row]) begin
                        if (deb_done) begin
                            pressed_nxt = 1'b0;
                            cnt_nxt     = '0;
                            col_nxt     = col + COL_W'(1);
                            state_nxt   = SCAN;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    assign kp.key_col     = col_onehot_n(col);
    assign kp.key_valid   = valid;
    assign kp.key_code    = code;
    assign kp.key_pressed = pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Switch-matrix bench for keypad_scanner with a strobe-level
// reference model; directed scenarios then random key traffic.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [19:0] closed = '0;
    logic [4:0]  pins;

    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV (SD),
        .DEB_CNT  (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    // A closed switch pulls its row low only while its column is driven.
    always_comb begin
        pins = '1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 5; r++) begin
                if (closed[c*5+r] && !kif.key_col[c]) pins[r] = 1'b0;
            end
        end
    end

    assign kif.key_row = pins;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_pulse = 0;

    int       m_div, m_col, m_mode, m_cnt;
    int       m_ccol, m_crow, m_code;
    bit       m_valid, m_pressed;
    bit [4:0] m_s1, m_s2;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int low_row(bit [4:0] v);
        for (int i = 0; i < 5; i++) if (!v[i]) return i;
        return -1;
    endfunction

    // Effect of one rising edge, given rst and the pin levels now.
    task automatic model_edge();
        int r;
        if (rst) begin
            m_div = 0; m_col = 0; m_mode = 0; m_cnt = 0;
            m_ccol = 0; m_crow = 0; m_code = 0;
            m_valid = 0; m_pressed = 0;
            m_s1 = '1; m_s2 = '1;
            return;
        end
        m_valid = 0;
        if (m_div == SD - 1) begin
            r = low_row(m_s2);
            if (m_mode == 0) begin
                if (r < 0) m_col = (m_col + 1) % 4;
                else begin
                    m_ccol = m_col; m_crow = r; m_cnt = 1; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (r == m_crow) begin
                    m_cnt++;
                    if (m_cnt == DB) begin
                        m_valid = 1; m_pressed = 1;
                        m_code = m_ccol * 5 + m_crow;
                        m_mode = 2; m_cnt = 0;
                    end
                end else begin
                    m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (m_s2[m_crow]) begin
                    m_cnt++;
                    if (m_cnt == DB) begin
                        m_pressed = 0; m_mode = 0; m_cnt = 0;
                        m_col = (m_col + 1) % 4;
                    end
                end else m_cnt = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = pins;
        m_div = (m_div + 1) % SD;
    endtask

    task automatic tick();
        #1;
        model_edge();
        @(negedge clk);
        if (kif.key_valid) n_pulse++;
        chk("col", kif.key_col, 4'hF ^ (1 << m_col));
        chk("valid", kif.key_valid, m_valid);
        chk("code", kif.key_code, m_code);
        chk("pressed", kif.key_pressed, m_pressed);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_mode(int mode, int limit, string tag);
        for (int i = 0; i < limit && m_mode != mode; i++) tick();
        chk(tag, m_mode, mode);
    endtask

    task automatic wait_col(int c, int limit, string tag);
        for (int i = 0; i < limit && !(m_col == c && m_mode == 0); i++)
            tick();
        chk(tag, m_col, c);
    endtask

    task automatic press_release(int key, int exp_code, string tag);
        int p0;
        p0 = n_pulse;
        closed = '0;
        closed[key] = 1'b1;
        wait_mode(2, 80, {tag, "_held"});
        run(4);
        chk({tag, "_code"}, kif.key_code, exp_code);
        chk({tag, "_pressed"}, kif.key_pressed, 1);
        closed = '0;
        wait_mode(0, 24, {tag, "_rel"});
        chk({tag, "_pulses"}, n_pulse - p0, 1);
    endtask

    initial begin
        int p0;
        int k;
        rst = 1'b1;
        closed = '0;
        run(2);
        rst = 1'b0;
        chk("rst_col", kif.key_col, 4'hE);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_code", kif.key_code, 0);
        chk("rst_pressed", kif.key_pressed, 0);

        p0 = n_pulse;
        run(3);
        chk("idle_col0", kif.key_col, 4'hE);
        run(1);
        chk("idle_col1", kif.key_col, 4'hD);
        run(4);
        chk("idle_col2", kif.key_col, 4'hB);
        run(4);
        chk("idle_col3", kif.key_col, 4'h7);
        run(4);
        chk("idle_wrap", kif.key_col, 4'hE);
        chk("idle_pulses", n_pulse - p0, 0);

        closed[0] = 1'b1;
        wait_mode(2, 80, "k00_held");
        run(8);
        chk("k00_code", kif.key_code, 0);
        chk("k00_col", kif.key_col, 4'hE);
        closed = '0;
        wait_mode(0, 24, "k00_rel");
        chk("k00_rel_col", kif.key_col, 4'hD);
        chk("k00_rel_pressed", kif.key_pressed, 0);

        press_release(3*5+4, 19, "k34");

        p0 = n_pulse;
        closed = '0;
        closed[2*5+1] = 1'b1;
        closed[2*5+3] = 1'b1;
        wait_mode(2, 80, "k2x_held");
        run(4);
        chk("k2x_code", kif.key_code, 11);
        closed = '0;
        wait_mode(0, 24, "k2x_rel");
        chk("k2x_pulses", n_pulse - p0, 1);

        p0 = n_pulse;
        wait_col(1, 40, "bnc_col1");
        closed[1*5+2] = 1'b1;
        wait_mode(1, 8, "bnc_det");
        closed = '0;
        wait_mode(0, 8, "bnc_abort");
        chk("bnc_col", kif.key_col, 4'hB);
        run(8);
        chk("bnc_pulses", n_pulse - p0, 0);

        p0 = n_pulse;
        closed[0*5+1] = 1'b1;
        wait_mode(2, 80, "gl_held");
        closed = '0;
        for (int i = 0; i < 12 && m_cnt != 1; i++) tick();
        chk("gl_cnt1", m_cnt, 1);
        closed[0*5+1] = 1'b1;
        run(8);
        chk("gl_still", kif.key_pressed, 1);
        closed = '0;
        wait_mode(0, 24, "gl_rel");
        chk("gl_pulses", n_pulse - p0, 1);

        p0 = n_pulse;
        closed[2*5+0] = 1'b1;
        wait_mode(1, 80, "rd_det");
        rst = 1'b1;
        closed = '0;
        tick();
        rst = 1'b0;
        chk("rd_col", kif.key_col, 4'hE);
        chk("rd_valid", kif.key_valid, 0);
        run(12);
        chk("rd_pulses", n_pulse - p0, 0);

        closed[3*5+2] = 1'b1;
        wait_mode(2, 80, "rh_held");
        p0 = n_pulse;
        rst = 1'b1;
        closed = '0;
        tick();
        rst = 1'b0;
        chk("rh_pressed", kif.key_pressed, 0);
        chk("rh_code", kif.key_code, 0);
        chk("rh_col", kif.key_col, 4'hE);
        run(12);
        chk("rh_pulses", n_pulse - p0, 0);

        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 19);
            closed = '0;
            closed[k] = 1'b1;
            if ($urandom_range(0, 3) == 0)
                closed[$urandom_range(0, 19)] = 1'b1;
            run($urandom_range(1, 70));
            closed = '0;
            run($urandom_range(1, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
